// File: rtl/spwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : spwm_capture
// Description : Measures an incoming sine-PWM waveform. Reports the high time
//               and rise-to-rise period of each completed PWM period, indexes
//               samples within a frame, and flags the long low gap that ends a
//               frame as well as an input stuck high.
// Revision    : 1.0 - initial release
// ============================================================================
module spwm_capture #(
    parameter int CNT_W       = 16,
    parameter int IDX_W       = 10,
    parameter int IDLE_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period_time,
    output logic [IDX_W-1:0] sample_idx,
    output logic             sample_valid,
    output logic             gap_det,
    output logic             err_stuck
);

    // Run-length counter is sized for the idle limit, independent of CNT_W,
    // so stuck/gap detection still works when the measurement counters saturate.
    localparam int RUN_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [1:0]       c_st_idle = 2'd0;
    localparam logic [1:0]       c_st_high = 2'd1;
    localparam logic [1:0]       c_st_low  = 2'd2;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [RUN_W-1:0] c_run_max = '1;
    localparam logic [RUN_W-1:0] c_run_lim = RUN_W'(IDLE_CYCLES);

    logic             r_s1, r_s2, r_s3;
    logic             w_rise, w_fall;
    logic [1:0]       r_state, w_state_next;

    logic [CNT_W-1:0] r_hi_cnt, w_hi_next, w_hi_inc;
    logic [CNT_W-1:0] r_per_cnt, w_per_next, w_per_inc;
    logic [RUN_W-1:0] r_run_cnt, w_run_next, w_run_inc;
    logic [IDX_W-1:0] r_idx, w_idx_next;

    logic             w_cap, w_gap, w_stuck;
    logic [CNT_W-1:0] r_high_time, r_period_time;
    logic [IDX_W-1:0] r_sample_idx;
    logic             r_sample_valid, r_gap_det, r_err_stuck;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    // Saturating increments: measurement counters never wrap.
    assign w_hi_inc  = (r_hi_cnt  == c_cnt_max) ? r_hi_cnt  : r_hi_cnt  + CNT_W'(1);
    assign w_per_inc = (r_per_cnt == c_cnt_max) ? r_per_cnt : r_per_cnt + CNT_W'(1);
    assign w_run_inc = (r_run_cnt == c_run_max) ? r_run_cnt : r_run_cnt + RUN_W'(1);

    // Two-flop synchronizer plus a delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: a rise always wins over an expiring low run.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_rise) begin
                    w_state_next = c_st_high;
                end
            end
            c_st_high: begin
                if (w_fall) begin
                    w_state_next = c_st_low;
                end else if (r_s2 && (w_run_inc == c_run_lim)) begin
                    w_state_next = c_st_idle;
                end
            end
            c_st_low: begin
                if (w_rise) begin
                    w_state_next = c_st_high;
                end else if (w_run_inc == c_run_lim) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Counter updates and strobe requests for the current state.
    always_comb begin
        w_hi_next  = r_hi_cnt;
        w_per_next = r_per_cnt;
        w_run_next = r_run_cnt;
        w_idx_next = r_idx;
        w_cap      = 1'b0;
        w_gap      = 1'b0;
        w_stuck    = 1'b0;
        case (r_state)
            c_st_idle: begin
                // First rise of a frame opens a period but has nothing to report.
                if (w_rise) begin
                    w_hi_next  = CNT_W'(1);
                    w_per_next = CNT_W'(1);
                    w_run_next = RUN_W'(1);
                    w_idx_next = '0;
                end
            end
            c_st_high: begin
                if (w_fall) begin
                    w_per_next = w_per_inc;
                    w_run_next = '0;
                end else if (r_s2) begin
                    if (w_run_inc == c_run_lim) begin
                        w_stuck = 1'b1;
                    end else begin
                        w_hi_next  = w_hi_inc;
                        w_per_next = w_per_inc;
                        w_run_next = w_run_inc;
                    end
                end
            end
            c_st_low: begin
                if (w_rise) begin
                    w_cap      = 1'b1;
                    w_idx_next = r_idx + IDX_W'(1);
                    w_hi_next  = CNT_W'(1);
                    w_per_next = CNT_W'(1);
                    w_run_next = RUN_W'(1);
                end else if (w_run_inc == c_run_lim) begin
                    w_gap      = 1'b1;
                    w_idx_next = '0;
                end else begin
                    w_per_next = w_per_inc;
                    w_run_next = w_run_inc;
                end
            end
            default: begin
                w_hi_next = r_hi_cnt;
            end
        endcase
    end

    // Measurement counters and registered outputs; results hold between strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi_cnt       <= '0;
            r_per_cnt      <= '0;
            r_run_cnt      <= '0;
            r_idx          <= '0;
            r_high_time    <= '0;
            r_period_time  <= '0;
            r_sample_idx   <= '0;
            r_sample_valid <= 1'b0;
            r_gap_det      <= 1'b0;
            r_err_stuck    <= 1'b0;
        end else begin
            r_hi_cnt       <= w_hi_next;
            r_per_cnt      <= w_per_next;
            r_run_cnt      <= w_run_next;
            r_idx          <= w_idx_next;
            r_sample_valid <= w_cap;
            r_gap_det      <= w_gap;
            r_err_stuck    <= w_stuck;
            if (w_cap) begin
                r_high_time   <= r_hi_cnt;
                r_period_time <= r_per_cnt;
                r_sample_idx  <= r_idx;
            end
        end
    end

    assign high_time    = r_high_time;
    assign period_time  = r_period_time;
    assign sample_idx   = r_sample_idx;
    assign sample_valid = r_sample_valid;
    assign gap_det      = r_gap_det;
    assign err_stuck    = r_err_stuck;

endmodule
`default_nettype wire
